// File: rtl/pc_select_unit_pkg.sv
// pc_select_unit_pkg: shared defaults and FSM state type for the PC select unit
//
// Contents:
//   XLEN_DEF      default PC / address width in bits
//   INC_DEF       default sequential PC increment in bytes
//   RESET_VEC_DEF default PC loaded on reset
//   state_t       fetch PC FSM states {BOOT, RUN, PEND}
package pc_select_unit_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          INC_DEF       = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Width of a binary index able to address n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_select_unit_prio_arb.sv
// prio_arb: fixed-priority one-hot arbiter, lowest request index wins
//
// Ports:
//   req    in  NSRC  request vector
//   gnt    out NSRC  one-hot grant (all zero when no request)
//   idx    out IW    binary index of the granted request (0 when none)
//   any    out 1     at least one request is present
module prio_arb
    import pc_select_unit_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IW   = idx_w(NSRC)
) (
    input  logic [NSRC-1:0] req,
    output logic [NSRC-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan from the lowest priority upwards so the last hit (lowest index) wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pc_select_unit.sv
// pc_select_unit: registered fetch PC with prioritised redirects, stall hold and a pending-redirect buffer
//
// Ports:
//   clk            in  1          rising-edge clock
//   rst_n          in  1          asynchronous active-low reset
//   stall          in  1          hold PC this cycle
//   redir_valid    in  NSRC       per-source redirect request (index 0 = highest priority)
//   redir_addr     in  NSRC*XLEN  packed targets, source i at [i*XLEN +: XLEN]
//   redir_ack      out NSRC       one-hot combinational grant, same cycle as acceptance
//   pc             out XLEN       current fetch address
//   pc_valid       out 1          PC is valid for fetch
//   redir_pending  out 1          a redirect is buffered awaiting stall release
//   misalign       out 1          one-cycle pulse after accepting a target with addr[1:0] != 0
module pc_select_unit
    import pc_select_unit_pkg::*;
#(
    parameter int             XLEN      = XLEN_DEF,
    parameter int             NSRC      = 4,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int             INC       = INC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [NSRC-1:0]      redir_valid,
    input  logic [NSRC*XLEN-1:0] redir_addr,
    output logic [NSRC-1:0]      redir_ack,
    output logic [XLEN-1:0]      pc,
    output logic                 pc_valid,
    output logic                 redir_pending,
    output logic                 misalign
);

    localparam int IW = idx_w(NSRC);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic [IW-1:0]   pend_idx_q, pend_idx_d;
    logic            misalign_q, misalign_d;

    logic [NSRC-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            accept;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] tgt_aligned;

    prio_arb #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_arb (
        .req (redir_valid),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign tgt         = redir_addr[int'(gnt_idx) * XLEN +: XLEN];
    assign tgt_aligned = {tgt[XLEN-1:2], 2'b00};

    // While a redirect is buffered, only a source of equal or higher priority
    // than the buffered one may replace it; lower-priority sources wait unacked.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_valid_d  = pc_valid_q;
        pend_addr_d = pend_addr_q;
        pend_idx_d  = pend_idx_q;
        accept      = 1'b0;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
            RUN: begin
                accept = gnt_any;
                if (accept && stall) begin
                    pend_addr_d = tgt_aligned;
                    pend_idx_d  = gnt_idx;
                    state_d     = PEND;
                end else if (accept) begin
                    pc_d = tgt_aligned;
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(INC);
                end
            end
            PEND: begin
                accept = gnt_any && (gnt_idx <= pend_idx_q);
                if (stall && accept) begin
                    pend_addr_d = tgt_aligned;
                    pend_idx_d  = gnt_idx;
                end else if (!stall) begin
                    pc_d    = accept ? tgt_aligned : pend_addr_q;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        misalign_d = accept && (tgt[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            pc_valid_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_idx_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            pend_addr_q <= pend_addr_d;
            pend_idx_q  <= pend_idx_d;
            misalign_q  <= misalign_d;
        end
    end

    assign redir_ack     = accept ? gnt : '0;
    assign pc            = pc_q;
    assign pc_valid      = pc_valid_q;
    assign redir_pending = (state_q == PEND);
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// tb_pc_select_unit: directed self-checking bench for pc_select_unit
module tb_pc_select_unit;

    logic         clk;
    logic         rst_n;
    logic         stall;
    logic [3:0]   redir_valid;
    logic [127:0] redir_addr;
    logic [3:0]   redir_ack;
    logic [31:0]  pc;
    logic         pc_valid;
    logic         redir_pending;
    logic         misalign;

    int n_checks = 0;
    int n_fail   = 0;

    pc_select_unit #(
        .XLEN      (32),
        .NSRC      (4),
        .RESET_VEC (32'h0000_0000),
        .INC       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redir_valid   (redir_valid),
        .redir_addr    (redir_addr),
        .redir_ack     (redir_ack),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .redir_pending (redir_pending),
        .misalign      (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int src, input logic [31:0] a);
        redir_addr[src*32 +: 32] = a;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redir_valid = '0;
        redir_addr  = '0;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_pending", {31'b0, redir_pending}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        #9;
        rst_n = 1'b1;
        // Redirect during BOOT must be ignored.
        redir_valid = 4'b0001;
        set_addr(0, 32'h0000_0800);
        #1;
        check("boot_ack", {28'b0, redir_ack}, 32'h0);
        step();
        redir_valid = '0;
        check("boot_pc", pc, 32'h0);
        check("boot_valid", {31'b0, pc_valid}, 32'h1);
        step();
        check("run_pc4", pc, 32'h4);
        step();
        check("run_pc8", pc, 32'h8);

        // Priority: sources 1 and 2 both valid, source 1 wins.
        redir_valid = 4'b0110;
        set_addr(1, 32'h0000_0100);
        set_addr(2, 32'h0000_0200);
        #1;
        check("prio_ack", {28'b0, redir_ack}, 32'h2);
        step();
        redir_valid = 4'b0100;
        check("prio_pc", pc, 32'h100);
        #1;
        check("prio_ack2", {28'b0, redir_ack}, 32'h4);
        step();
        redir_valid = '0;
        check("prio_pc2", pc, 32'h200);
        step();
        check("prio_inc", pc, 32'h204);

        // Stall capture.
        stall       = 1'b1;
        redir_valid = 4'b0100;
        set_addr(2, 32'h0000_0300);
        #1;
        check("cap_ack", {28'b0, redir_ack}, 32'h4);
        step();
        redir_valid = '0;
        check("cap_pend", {31'b0, redir_pending}, 32'h1);
        check("cap_pc", pc, 32'h204);
        step();
        step();
        check("cap_hold", pc, 32'h204);
        check("cap_valid", {31'b0, pc_valid}, 32'h1);
        stall = 1'b0;
        step();
        check("cap_rel_pc", pc, 32'h300);
        check("cap_rel_pend", {31'b0, redir_pending}, 32'h0);
        step();
        check("cap_inc", pc, 32'h304);

        // Override in PEND.
        stall       = 1'b1;
        redir_valid = 4'b0100;
        set_addr(2, 32'h0000_0300);
        step();
        redir_valid = 4'b0001;
        set_addr(0, 32'h0000_0080);
        #1;
        check("ovr_ack0", {28'b0, redir_ack}, 32'h1);
        step();
        redir_valid = 4'b1000;
        set_addr(3, 32'h0000_0400);
        #1;
        check("ovr_ack3", {28'b0, redir_ack}, 32'h0);
        step();
        check("ovr_hold", pc, 32'h304);
        stall = 1'b0;
        #1;
        check("ovr_rel_ack3", {28'b0, redir_ack}, 32'h0);
        step();
        check("ovr_pc", pc, 32'h80);
        check("ovr_pend", {31'b0, redir_pending}, 32'h0);
        #1;
        check("run_ack3", {28'b0, redir_ack}, 32'h8);
        step();
        redir_valid = '0;
        check("run_pc3", pc, 32'h400);

        // Misalign and wrap.
        redir_valid = 4'b0010;
        set_addr(1, 32'h0000_0103);
        step();
        redir_valid = '0;
        check("mis_pc", pc, 32'h100);
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        step();
        check("mis_clear", {31'b0, misalign}, 32'h0);
        check("mis_inc", pc, 32'h104);
        redir_valid = 4'b0001;
        set_addr(0, 32'hFFFF_FFFC);
        step();
        redir_valid = '0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_mis", {31'b0, misalign}, 32'h0);
        step();
        check("wrap_zero", pc, 32'h0);

        // Asynchronous reset while a redirect is pending.
        stall       = 1'b1;
        redir_valid = 4'b0100;
        set_addr(2, 32'h0000_0500);
        step();
        redir_valid = '0;
        check("arst_pre_pend", {31'b0, redir_pending}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_pend", {31'b0, redir_pending}, 32'h0);
        check("arst_valid", {31'b0, pc_valid}, 32'h0);
        step();
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_valid", {31'b0, pc_valid}, 32'h1);
        check("post_rst_pc", pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
